pu_cycle_gate: RTL and testbench
================================

Name: pu_cycle_gate

Overview:
- Downstream stage of the microcode sequencer. Consumes its microcode word stream and its cycle-boundary strobe, and forwards whole computational cycles to the processing-unit bus.
- Adds run/stop/single-cycle control aligned to cycle boundaries, a one-clock register stage, and a completed-cycle counter.
- While not running, drives a NOP word so processing units stay inert.

Parameters:
- MICROCODE_WIDTH, 16, width of the microcode word.
- NOP_WORD, {MICROCODE_WIDTH{1'b0}}, word driven when not forwarding.
- CYCLE_COUNT_WIDTH, 16, width of cycle_count.
- CYCLE_LIMIT, 8, auto-stop cycle count; used only with CYCLE_LIMIT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- signals_in  in  MICROCODE_WIDTH  microcode word from the sequencer.
- cycle_in  in  1  high while the sequencer presents the first word of a cycle.
- start  in  1  request continuous run (level sampled each clk).
- stop  in  1  request halt at the end of the current cycle.
- single  in  1  request exactly one cycle.
- signals_out  out  MICROCODE_WIDTH  registered word to the PU bus.
- cycle_out  out  1  high with the first forwarded word of each cycle.
- running  out  1  high in RUN or DRAIN.
- cycle_count  out  CYCLE_COUNT_WIDTH  count of completed forwarded cycles.
- done  out  1  one-clock pulse when returning to IDLE after forwarding.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE.
  - signals_out=NOP_WORD; cycle_out=0; running=0; cycle_count=0; done=0.
  - single_mode=0; stop_pending=0.
- Latency: signals_out and cycle_out follow signals_in and cycle_in by exactly one clk while forwarding.
- States: IDLE, ARM, RUN, DRAIN.
- IDLE:
  - stop high: stay IDLE. Stop has priority over start and single.
  - Else start or single: go to ARM, with single_mode=single. If both are high, single wins.
- ARM:
  - stop high: go to IDLE, no done pulse.
  - Else cycle_in high: register signals_in, set cycle_out=1, go to RUN (DRAIN if single_mode).
  - Otherwise hold NOP.
- RUN: register signals_in every clk.
  - At each later cycle_in=1 (boundary), cycle_count increments, wrapping mod 2^CYCLE_COUNT_WIDTH, and forwarding continues.
  - stop seen: go to DRAIN, keep forwarding.
- DRAIN: forward until the next cycle_in=1. On that clk:
  - cycle_count increments.
  - signals_out<=NOP_WORD; cycle_out<=0; done<=1.
  - Go to IDLE.
- start/single are ignored outside IDLE. stop in DRAIN is a no-op.
- A boundary and stop arriving in the same clk in RUN: the boundary starts a new cycle (cycle_out=1, count increments), then the state goes to DRAIN. That new cycle completes.
- cycle_in high every clk (one-word cycle): ARM→DRAIN forwards one word, then IDLE on the next clk with count+1.
- Reset mid-run: everything returns to reset values immediately. A partial cycle is not counted.
- cycle_out is never high while signals_out=NOP_WORD.

Optional Feature:
- Macro: CYCLE_LIMIT_EN.
- Defined:
  - A run counter clears on IDLE→ARM and increments at each completed cycle.
  - When it reaches CYCLE_LIMIT in RUN, an internal stop is raised, so the cycle in progress drains and the block goes to IDLE with done.
  - CYCLE_LIMIT=0 disables the limit.
- Undefined: no run counter; CYCLE_LIMIT is ignored; only stop and single end a run.

Decomposition:
- Package pu_cycle_gate_pkg holds:
  - state enum (IDLE, ARM, RUN, DRAIN) and its encoding width;
  - default NOP word constant;
  - default CYCLE_COUNT_WIDTH.
- One sub-module, pu_cycle_gate_counter: wrapping counter with clear/increment and async active-low reset. Instantiated for cycle_count, and for the run counter under CYCLE_LIMIT_EN.

Test Plan:
- Reset release, no requests, cycle_in pulses every 5 clk → signals_out=NOP_WORD, cycle_out=0, running=0, cycle_count=0 throughout.
- single pulse, cycle length 5, words 0x11..0x15 → after the next boundary, exactly 0x11..0x15 appear one clk delayed; cycle_out is high with 0x11 only; done pulses once; cycle_count=1.
- start held, 3 cycles, then stop mid-third cycle → three full cycles forwarded, cycle_count=3, done once, NOP afterwards. No word is truncated.
- stop asserted while in ARM, before any boundary → IDLE, no words forwarded, done=0, cycle_count unchanged.
- rst_n dropped mid-cycle during RUN at cycle_count=2 → signals_out=NOP_WORD and cycle_count=0 immediately (async). No done pulse.
- With CYCLE_LIMIT_EN and CYCLE_LIMIT=2, start held → exactly 2 cycles forwarded, then done, then IDLE. A second start runs 2 more, giving cycle_count=4.

Source files
------------

// File: rtl/pu_cycle_gate_pkg.sv
// Shared types and defaults for the processing-unit cycle gate.
package pu_cycle_gate_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEFAULT_MICROCODE_WIDTH   = 16;
  localparam int DEFAULT_CYCLE_COUNT_WIDTH = 16;

  localparam logic [DEFAULT_MICROCODE_WIDTH-1:0] DEFAULT_NOP_WORD = '0;

endpackage

// File: rtl/pu_cycle_gate_counter.sv
// Wrapping up-counter with synchronous clear (clear wins) and async active-low reset.
module pu_cycle_gate_counter
  import pu_cycle_gate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_CYCLE_COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

endmodule

// File: rtl/pu_cycle_gate.sv
// Gates whole microcode cycles onto the PU bus with run/stop/single control.
// Optional auto-stop after CYCLE_LIMIT cycles when CYCLE_LIMIT_EN is defined.
module pu_cycle_gate
  import pu_cycle_gate_pkg::*;
#(
  parameter int                         MICROCODE_WIDTH   = DEFAULT_MICROCODE_WIDTH,
  parameter logic [MICROCODE_WIDTH-1:0] NOP_WORD          = {MICROCODE_WIDTH{1'b0}},
  parameter int                         CYCLE_COUNT_WIDTH = DEFAULT_CYCLE_COUNT_WIDTH,
  parameter int                         CYCLE_LIMIT       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [MICROCODE_WIDTH-1:0]   signals_in,
  input  logic                         cycle_in,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         single,
  output logic [MICROCODE_WIDTH-1:0]   signals_out,
  output logic                         cycle_out,
  output logic                         running,
  output logic [CYCLE_COUNT_WIDTH-1:0] cycle_count,
  output logic                         done
);

  if (CYCLE_LIMIT < 0) begin : g_bad_limit
    $error("pu_cycle_gate: CYCLE_LIMIT must be non-negative");
  end

  state_t                       state, state_nxt;
  logic                         single_mode, single_nxt;
  logic [MICROCODE_WIDTH-1:0]   sig_nxt;
  logic                         cyc_nxt, done_nxt;
  logic                         cnt_inc, arm_go, limit_stop;

  pu_cycle_gate_counter #(.WIDTH(CYCLE_COUNT_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (cnt_inc),
    .count (cycle_count)
  );

`ifdef CYCLE_LIMIT_EN
  logic [CYCLE_COUNT_WIDTH-1:0] run_count;
  logic [CYCLE_COUNT_WIDTH:0]   started;

  pu_cycle_gate_counter #(.WIDTH(CYCLE_COUNT_WIDTH)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (arm_go),
    .inc   (cnt_inc),
    .count (run_count)
  );

  // Cycles started in this run, counting one that begins on this clk; stopping
  // as soon as the LIMIT-th cycle starts lets exactly LIMIT cycles complete.
  assign started    = {1'b0, run_count} +
                      (cycle_in ? (CYCLE_COUNT_WIDTH+1)'(2) : (CYCLE_COUNT_WIDTH+1)'(1));
  assign limit_stop = (CYCLE_LIMIT != 0) && (state == RUN) && (int'(started) >= CYCLE_LIMIT);
`else
  assign limit_stop = 1'b0;
`endif

  assign running = (state == RUN) || (state == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      single_mode <= 1'b0;
      signals_out <= NOP_WORD;
      cycle_out   <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      single_mode <= single_nxt;
      signals_out <= sig_nxt;
      cycle_out   <= cyc_nxt;
      done        <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    single_nxt = single_mode;
    sig_nxt    = NOP_WORD;
    cyc_nxt    = 1'b0;
    done_nxt   = 1'b0;
    cnt_inc    = 1'b0;
    arm_go     = 1'b0;
    case (state)
      IDLE: begin
        if (!stop && (start || single)) begin
          state_nxt  = ARM;
          single_nxt = single;
          arm_go     = 1'b1;
        end
      end
      ARM: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (cycle_in) begin
          sig_nxt   = signals_in;
          cyc_nxt   = 1'b1;
          state_nxt = single_mode ? DRAIN : RUN;
        end
      end
      RUN: begin
        // A boundary coinciding with stop still opens a new cycle, which then drains.
        sig_nxt = signals_in;
        cyc_nxt = cycle_in;
        cnt_inc = cycle_in;
        if (stop || limit_stop) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cycle_in) begin
          cnt_inc   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          sig_nxt = signals_in;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pu_cycle_gate.sv
// Directed self-checking bench for pu_cycle_gate (default build and CYCLE_LIMIT_EN build).
module tb_pu_cycle_gate;

  localparam int W  = 16;
  localparam int CW = 16;
`ifdef CYCLE_LIMIT_EN
  localparam int LIMIT = 2;
`else
  localparam int LIMIT = 8;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  signals_in = '0;
  logic          cycle_in = 1'b0, start = 1'b0, stop = 1'b0, single = 1'b0;
  logic [W-1:0]  signals_out;
  logic          cycle_out, running, done;
  logic [CW-1:0] cycle_count;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic          st, sp, sg;
    logic [W-1:0]  w;
    logic          ci;
    logic [W-1:0]  eo;
    logic          eco, er, ed;
    logic [CW-1:0] ec;
  } vec_t;

  pu_cycle_gate #(
    .MICROCODE_WIDTH   (W),
    .NOP_WORD          ({W{1'b0}}),
    .CYCLE_COUNT_WIDTH (CW),
    .CYCLE_LIMIT       (LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .signals_in  (signals_in),
    .cycle_in    (cycle_in),
    .start       (start),
    .stop        (stop),
    .single      (single),
    .signals_out (signals_out),
    .cycle_out   (cycle_out),
    .running     (running),
    .cycle_count (cycle_count),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic st, input logic sp, input logic sg,
                              input logic [W-1:0] w, input logic ci,
                              input logic [W-1:0] eo, input logic eco, input logic er,
                              input logic ed, input logic [CW-1:0] ec);
    vec_t v;
    v.st = st; v.sp = sp; v.sg = sg; v.w = w; v.ci = ci;
    v.eo = eo; v.eco = eco; v.er = er; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  // Apply one clk of stimulus; outputs are sampled 1ns after the edge.
  task automatic drive(input vec_t v);
    start = v.st; stop = v.sp; single = v.sg; signals_in = v.w; cycle_in = v.ci;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    start = 0; stop = 0; single = 0; signals_in = '0; cycle_in = 0;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if ({signals_out, cycle_out, running, done, cycle_count} !== {W'(0), 1'b0, 1'b0, 1'b0, CW'(0)}) begin
      n_fail++;
      $display("FAIL reset_state: got out=%h co=%b run=%b done=%b cnt=%0d, want all zero",
               signals_out, cycle_out, running, done, cycle_count);
    end
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      drive(mk(0, 0, 0, W'(16'hA0 + i), (i % 5) == 0, '0, 0, 0, 0, '0));
      n_chk++;
      if ({signals_out, cycle_out, running, done, cycle_count} !== {W'(0), 1'b0, 1'b0, 1'b0, CW'(0)}) begin
        n_fail++;
        $display("FAIL idle_no_request step %0d: got out=%h co=%b run=%b done=%b cnt=%0d, want all zero",
                 i, signals_out, cycle_out, running, done, cycle_count);
      end
    end
  endtask

  task automatic test_single();
    vec_t v[$];
    apply_reset();
    v.push_back(mk(0, 0, 1, 16'h00AA, 0, 16'h0000, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0099, 0, 16'h0000, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0011, 1, 16'h0011, 1, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0012, 0, 16'h0012, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0013, 0, 16'h0013, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0014, 0, 16'h0014, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0015, 0, 16'h0015, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0021, 1, 16'h0000, 0, 0, 1, 1));
    v.push_back(mk(0, 0, 0, 16'h0022, 0, 16'h0000, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 16'h0023, 1, 16'h0000, 0, 0, 0, 1));
    foreach (v[i]) begin
      drive(v[i]);
      n_chk++;
      if ({signals_out, cycle_out, running, done, cycle_count} !== {v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec}) begin
        n_fail++;
        $display("FAIL single_cycle step %0d: got out=%h co=%b run=%b done=%b cnt=%0d, want out=%h co=%b run=%b done=%b cnt=%0d",
                 i, signals_out, cycle_out, running, done, cycle_count, v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec);
      end
    end
  endtask

  task automatic test_start_stop();
    vec_t v[$];
    int cnt = 0;
    logic [W-1:0] w;
    apply_reset();
    v.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
    for (int k = 1; k <= 3; k++) begin
      for (int i = 1; i <= 5; i++) begin
        w = W'(k * 256 + i);
        if (i == 1 && k > 1) cnt++;
        v.push_back(mk(k < 3, (k == 3 && i == 3), 0, w, i == 1, w, i == 1, 1, 0, CW'(cnt)));
      end
    end
    v.push_back(mk(0, 0, 0, 16'h0401, 1, 16'h0000, 0, 0, 1, 3));
    v.push_back(mk(0, 0, 0, 16'h0402, 0, 16'h0000, 0, 0, 0, 3));
    v.push_back(mk(0, 0, 0, 16'h0403, 1, 16'h0000, 0, 0, 0, 3));
    foreach (v[i]) begin
      drive(v[i]);
      n_chk++;
      if ({signals_out, cycle_out, running, done, cycle_count} !== {v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec}) begin
        n_fail++;
        $display("FAIL start_stop step %0d: got out=%h co=%b run=%b done=%b cnt=%0d, want out=%h co=%b run=%b done=%b cnt=%0d",
                 i, signals_out, cycle_out, running, done, cycle_count, v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec);
      end
    end
  endtask

  task automatic test_stop_priority_and_arm();
    vec_t v[$];
    apply_reset();
    v.push_back(mk(1, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0050, 1, 16'h0000, 0, 0, 0, 0));
    v.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 16'h0055, 1, 16'h0000, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0056, 0, 16'h0000, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0057, 1, 16'h0000, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      n_chk++;
      if ({signals_out, cycle_out, running, done, cycle_count} !== {v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec}) begin
        n_fail++;
        $display("FAIL stop_in_arm step %0d: got out=%h co=%b run=%b done=%b cnt=%0d, want out=%h co=%b run=%b done=%b cnt=%0d",
                 i, signals_out, cycle_out, running, done, cycle_count, v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec);
      end
    end
  endtask

  task automatic test_boundary_stop();
    vec_t v[$];
    apply_reset();
    v.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0031, 1, 16'h0031, 1, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0032, 0, 16'h0032, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0033, 0, 16'h0033, 0, 1, 0, 0));
    v.push_back(mk(0, 1, 0, 16'h0041, 1, 16'h0041, 1, 1, 0, 1));
    v.push_back(mk(1, 1, 0, 16'h0042, 0, 16'h0042, 0, 1, 0, 1));
    v.push_back(mk(0, 0, 0, 16'h0043, 0, 16'h0043, 0, 1, 0, 1));
    v.push_back(mk(0, 0, 0, 16'h0051, 1, 16'h0000, 0, 0, 1, 2));
    v.push_back(mk(0, 0, 0, 16'h0052, 0, 16'h0000, 0, 0, 0, 2));
    foreach (v[i]) begin
      drive(v[i]);
      n_chk++;
      if ({signals_out, cycle_out, running, done, cycle_count} !== {v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec}) begin
        n_fail++;
        $display("FAIL boundary_stop step %0d: got out=%h co=%b run=%b done=%b cnt=%0d, want out=%h co=%b run=%b done=%b cnt=%0d",
                 i, signals_out, cycle_out, running, done, cycle_count, v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec);
      end
    end
  endtask

  task automatic test_one_word();
    vec_t v[$];
    apply_reset();
    v.push_back(mk(1, 0, 1, 16'h0060, 1, 16'h0000, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0061, 1, 16'h0061, 1, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 16'h0062, 1, 16'h0000, 0, 0, 1, 1));
    v.push_back(mk(0, 0, 0, 16'h0063, 1, 16'h0000, 0, 0, 0, 1));
    foreach (v[i]) begin
      drive(v[i]);
      n_chk++;
      if ({signals_out, cycle_out, running, done, cycle_count} !== {v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec}) begin
        n_fail++;
        $display("FAIL one_word_cycle step %0d: got out=%h co=%b run=%b done=%b cnt=%0d, want out=%h co=%b run=%b done=%b cnt=%0d",
                 i, signals_out, cycle_out, running, done, cycle_count, v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t v[$];
    int cnt = 0;
    logic [W-1:0] w;
    apply_reset();
    v.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
    for (int k = 1; k <= 3; k++) begin
      for (int i = 1; i <= 3 && !(k == 3 && i == 3); i++) begin
        w = W'(16'h7000 + k * 16 + i);
        if (i == 1 && k > 1) cnt++;
        v.push_back(mk(1, 0, 0, w, i == 1, w, i == 1, 1, 0, CW'(cnt)));
      end
    end
    foreach (v[i]) begin
      drive(v[i]);
      n_chk++;
      if ({signals_out, cycle_out, running, done, cycle_count} !== {v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec}) begin
        n_fail++;
        $display("FAIL async_reset_prep step %0d: got out=%h co=%b run=%b done=%b cnt=%0d, want out=%h co=%b run=%b done=%b cnt=%0d",
                 i, signals_out, cycle_out, running, done, cycle_count, v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec);
      end
    end
    #2 rst_n = 0;
    #1;
    n_chk++;
    if ({signals_out, cycle_out, running, done, cycle_count} !== {W'(0), 1'b0, 1'b0, 1'b0, CW'(0)}) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got out=%h co=%b run=%b done=%b cnt=%0d, want all zero",
               signals_out, cycle_out, running, done, cycle_count);
    end
    #1 rst_n = 1;
    start = 0;
    drive(mk(0, 0, 0, 16'h7033, 1, '0, 0, 0, 0, '0));
    n_chk++;
    if ({signals_out, cycle_out, running, done, cycle_count} !== {W'(0), 1'b0, 1'b0, 1'b0, CW'(0)}) begin
      n_fail++;
      $display("FAIL async_reset_after: got out=%h co=%b run=%b done=%b cnt=%0d, want all zero",
               signals_out, cycle_out, running, done, cycle_count);
    end
  endtask

  task automatic test_cycle_limit();
    vec_t v[$];
    apply_reset();
    v.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
    v.push_back(mk(1, 0, 0, 16'h00A1, 1, 16'h00A1, 1, 1, 0, 0));
    v.push_back(mk(1, 0, 0, 16'h00A2, 0, 16'h00A2, 0, 1, 0, 0));
    v.push_back(mk(1, 0, 0, 16'h00A3, 0, 16'h00A3, 0, 1, 0, 0));
    v.push_back(mk(1, 0, 0, 16'h00B1, 1, 16'h00B1, 1, 1, 0, 1));
    v.push_back(mk(1, 0, 0, 16'h00B2, 0, 16'h00B2, 0, 1, 0, 1));
    v.push_back(mk(1, 0, 0, 16'h00B3, 0, 16'h00B3, 0, 1, 0, 1));
    v.push_back(mk(1, 0, 0, 16'h00C1, 1, 16'h0000, 0, 0, 1, 2));
    v.push_back(mk(1, 0, 0, 16'h00C2, 0, 16'h0000, 0, 0, 0, 2));
    v.push_back(mk(1, 0, 0, 16'h00C3, 0, 16'h0000, 0, 0, 0, 2));
    v.push_back(mk(1, 0, 0, 16'h00D1, 1, 16'h00D1, 1, 1, 0, 2));
    v.push_back(mk(1, 0, 0, 16'h00D2, 0, 16'h00D2, 0, 1, 0, 2));
    v.push_back(mk(1, 0, 0, 16'h00D3, 0, 16'h00D3, 0, 1, 0, 2));
    v.push_back(mk(1, 0, 0, 16'h00E1, 1, 16'h00E1, 1, 1, 0, 3));
    v.push_back(mk(1, 0, 0, 16'h00E2, 0, 16'h00E2, 0, 1, 0, 3));
    v.push_back(mk(0, 0, 0, 16'h00E3, 0, 16'h00E3, 0, 1, 0, 3));
    v.push_back(mk(0, 0, 0, 16'h00F1, 1, 16'h0000, 0, 0, 1, 4));
    v.push_back(mk(0, 0, 0, 16'h00F2, 0, 16'h0000, 0, 0, 0, 4));
    v.push_back(mk(0, 0, 0, 16'h00F3, 1, 16'h0000, 0, 0, 0, 4));
    foreach (v[i]) begin
      drive(v[i]);
      n_chk++;
      if ({signals_out, cycle_out, running, done, cycle_count} !== {v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec}) begin
        n_fail++;
        $display("FAIL cycle_limit step %0d: got out=%h co=%b run=%b done=%b cnt=%0d, want out=%h co=%b run=%b done=%b cnt=%0d",
                 i, signals_out, cycle_out, running, done, cycle_count, v[i].eo, v[i].eco, v[i].er, v[i].ed, v[i].ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stop_priority_and_arm();
    test_boundary_stop();
    test_one_word();
`ifdef CYCLE_LIMIT_EN
    test_cycle_limit();
`else
    test_start_stop();
    test_async_reset();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
